// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter and the arm top level.
// Exports the grant_t enum and the default data width.
`timescale 1ns/1ps
package dmem_arb_pkg;

  localparam int DMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    G_IDLE = 2'd0,
    G_CPU  = 2'd1,
    G_CAM  = 2'd2
  } grant_t;

endpackage

// File: rtl/cam_wr_fifo.sv
// Camera write FIFO: stores {addr,data} pixel writes for the arbiter.
// Ports: clk, reset (async low), i_push, i_pop, i_din, o_head, o_level.
`timescale 1ns/1ps
module cam_wr_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_din,
  output logic [W-1:0]             o_head,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointers wrap naturally; occupancy alone decides full/empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      unique case ({i_push, i_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_level = r_level;

endmodule

// File: rtl/dmem_arbiter.sv
// Data RAM arbiter: CPU has priority, camera writes queue in a FIFO,
// and a wait counter forces a camera slot after MAX_WAIT denials.
// Ports: CPU req/stall/rvalid/rdata, camera valid/ready, RAM port.
`timescale 1ns/1ps
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_WAIT   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cpu_req,
  input  logic                        cpu_we,
  input  logic [ADDR_W-1:0]           cpu_addr,
  input  logic [DATA_W-1:0]           cpu_wdata,
  output logic                        cpu_stall,
  output logic                        cpu_rvalid,
  output logic [DATA_W-1:0]           cpu_rdata,
  input  logic                        cam_valid,
  output logic                        cam_ready,
  input  logic [ADDR_W-1:0]           cam_addr,
  input  logic [DATA_W-1:0]           cam_data,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [DATA_W-1:0]           ram_wdata,
  output logic                        ram_we,
  input  logic [DATA_W-1:0]           ram_rdata,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int EW = ADDR_W + DATA_W;

  logic [EW-1:0]     w_head;
  logic [LW-1:0]     w_level;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_cam;
  logic              w_cpu;
  grant_t            w_grant;
  logic [WW-1:0]     w_wait_nxt;

  logic [WW-1:0]     r_wait_cnt;
  grant_t            r_last_grant;
  logic              r_rd_pend;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  cam_wr_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   ({cam_addr, cam_data}),
    .o_head  (w_head),
    .o_level (w_level)
  );

  assign w_empty    = (w_level == '0);
  assign w_full     = (w_level == LW'(FIFO_DEPTH));
  assign cam_ready  = !w_full;
  assign w_push     = cam_valid && cam_ready && reset;
  assign fifo_level = w_level;
  assign cpu_rdata  = ram_rdata;

  assign w_cam = !w_empty &&
                 (!cpu_req ||
                  (r_wait_cnt == WW'(MAX_WAIT)) ||
                  w_full);
  assign w_cpu = cpu_req && !w_cam;

  // Forcing idle while reset is low keeps the RAM untouched
  // even if the CPU still presents a store.
  always_comb begin
    w_grant = G_IDLE;
    if (reset) begin
      unique case (1'b1)
        w_cam:   w_grant = G_CAM;
        w_cpu:   w_grant = G_CPU;
        default: w_grant = G_IDLE;
      endcase
    end
  end

  always_comb begin
    ram_addr  = r_addr;
    ram_wdata = r_wdata;
    ram_we    = 1'b0;
    cpu_stall = 1'b0;
    w_pop     = 1'b0;
    unique case (w_grant)
      G_CPU: begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we    = cpu_we;
      end
      G_CAM: begin
        ram_addr  = w_head[EW-1:DATA_W];
        ram_wdata = w_head[DATA_W-1:0];
        ram_we    = 1'b1;
        cpu_stall = cpu_req;
        w_pop     = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if (w_empty || (w_grant == G_CAM)) begin
      w_wait_nxt = '0;
    end else if (r_wait_cnt != WW'(MAX_WAIT)) begin
      w_wait_nxt = r_wait_cnt + WW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt   <= '0;
      r_last_grant <= G_IDLE;
      r_rd_pend    <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      r_wait_cnt   <= w_wait_nxt;
      r_last_grant <= w_grant;
      r_rd_pend    <= (w_grant == G_CPU) && !cpu_we;
      r_addr       <= ram_addr;
      r_wdata      <= ram_wdata;
    end
  end

  assign cpu_rvalid = r_rd_pend && (r_last_grant == G_CPU);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter.
// Inputs change 1ns after posedge; outputs sampled on negedge.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        cam_valid;
  logic        cam_ready;
  logic [31:0] cam_addr;
  logic [31:0] cam_data;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [31:0] ram_rdata;
  logic [3:0]  fifo_level;

  int checks;
  int failures;

  dmem_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .FIFO_DEPTH (8),
    .MAX_WAIT   (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .cam_valid  (cam_valid),
    .cam_ready  (cam_ready),
    .cam_addr   (cam_addr),
    .cam_data   (cam_data),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_rdata  (ram_rdata),
    .fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
    cam_valid = 1'b1; cam_addr = 32'h50; cam_data = 32'h5;
    ram_rdata = '0;
    step(); step();
    @(negedge clk);
    checks++;
    if (cpu_stall !== 1'b0 || cpu_rvalid !== 1'b0 || ram_we !== 1'b0) begin
      failures++;
      $display("FAIL rst_ctl stall=%b rvalid=%b we=%b want 0 0 0",
               cpu_stall, cpu_rvalid, ram_we);
    end
    checks++;
    if (ram_addr !== 32'h0 || ram_wdata !== 32'h0) begin
      failures++;
      $display("FAIL rst_ram addr=%h wdata=%h want 0 0", ram_addr, ram_wdata);
    end
    checks++;
    if (fifo_level !== 4'd0 || cam_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_fifo level=%0d ready=%b want 0 1", fifo_level, cam_ready);
    end
    step();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (fifo_level !== 4'd0 || cam_ready !== 1'b1) begin
      failures++;
      $display("FAIL rel_fifo level=%0d ready=%b want 0 1", fifo_level, cam_ready);
    end
    step();
    cam_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_level !== 4'd1 || ram_we !== 1'b1 || ram_addr !== 32'h50) begin
      failures++;
      $display("FAIL rel_push level=%0d we=%b addr=%h want 1 1 50",
               fifo_level, ram_we, ram_addr);
    end
    step();
    @(negedge clk);
    checks++;
    if (fifo_level !== 4'd0 || ram_we !== 1'b0) begin
      failures++;
      $display("FAIL rel_drain level=%0d we=%b want 0 0", fifo_level, ram_we);
    end
    step();
  endtask

  task automatic test_load();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b0 || ram_addr !== 32'h10 || cpu_stall !== 1'b0) begin
      failures++;
      $display("FAIL ld_issue we=%b addr=%h stall=%b want 0 10 0",
               ram_we, ram_addr, cpu_stall);
    end
    step();
    cpu_req = 1'b0; cpu_addr = 32'h99;
    ram_rdata = 32'hCAFE_0010;
    @(negedge clk);
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hCAFE_0010) begin
      failures++;
      $display("FAIL ld_resp rvalid=%b rdata=%h want 1 cafe0010",
               cpu_rvalid, cpu_rdata);
    end
    checks++;
    if (ram_addr !== 32'h10 || ram_we !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold addr=%h we=%b want 10 0", ram_addr, ram_we);
    end
    step();
    @(negedge clk);
    checks++;
    if (cpu_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL ld_once rvalid=%b want 0", cpu_rvalid);
    end
    step();
  endtask

  task automatic test_cam_burst();
    logic [31:0] exp_a;
    cam_valid = 1'b1; cam_addr = 32'h100; cam_data = 32'hA0;
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b0) begin
      failures++;
      $display("FAIL cam_lat we=%b want 0", ram_we);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (i < 2) begin
        cam_addr = 32'h101 + 32'(i);
        cam_data = 32'hA1 + 32'(i);
      end else begin
        cam_valid = 1'b0;
      end
      exp_a = 32'h100 + 32'(i);
      @(negedge clk);
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== exp_a ||
          ram_wdata !== 32'hA0 + 32'(i)) begin
        failures++;
        $display("FAIL cam_wr%0d we=%b addr=%h data=%h want 1 %h %h",
                 i, ram_we, ram_addr, ram_wdata, exp_a, 32'hA0 + 32'(i));
      end
    end
    step();
    @(negedge clk);
    checks++;
    if (fifo_level !== 4'd0 || ram_we !== 1'b0) begin
      failures++;
      $display("FAIL cam_empty level=%0d we=%b want 0 0", fifo_level, ram_we);
    end
    step();
  endtask

  task automatic test_starvation();
    cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = 32'h40; cpu_wdata = 32'h55;
    cam_valid = 1'b1; cam_addr = 32'h300; cam_data = 32'h33;
    step();
    cam_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (cpu_stall !== 1'b0 || ram_addr !== 32'h40 || ram_we !== 1'b1) begin
        failures++;
        $display("FAIL starve_cpu%0d stall=%b addr=%h we=%b want 0 40 1",
                 c, cpu_stall, ram_addr, ram_we);
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (cpu_stall !== 1'b1 || ram_addr !== 32'h300 ||
        ram_wdata !== 32'h33 || ram_we !== 1'b1) begin
      failures++;
      $display("FAIL starve_cam stall=%b addr=%h data=%h we=%b want 1 300 33 1",
               cpu_stall, ram_addr, ram_wdata, ram_we);
    end
    step();
    @(negedge clk);
    checks++;
    if (cpu_stall !== 1'b0 || fifo_level !== 4'd0 || ram_addr !== 32'h40) begin
      failures++;
      $display("FAIL starve_after stall=%b level=%0d addr=%h want 0 0 40",
               cpu_stall, fifo_level, ram_addr);
    end
    cpu_req = 1'b0;
    step();
  endtask

  task automatic test_full();
    cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = 32'h44; cpu_wdata = 32'h66;
    cam_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      cam_addr = 32'h200 + 32'(k);
      cam_data = 32'(k);
      step();
    end
    cam_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_level !== 4'd8 || cam_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_lvl level=%0d ready=%b want 8 0", fifo_level, cam_ready);
    end
    checks++;
    if (cpu_stall !== 1'b1 || ram_we !== 1'b1 ||
        ram_addr !== 32'h201 || ram_wdata !== 32'h1) begin
      failures++;
      $display("FAIL full_gnt stall=%b we=%b addr=%h data=%h want 1 1 201 1",
               cpu_stall, ram_we, ram_addr, ram_wdata);
    end
    step();
    @(negedge clk);
    checks++;
    if (cam_ready !== 1'b1 || fifo_level !== 4'd7) begin
      failures++;
      $display("FAIL full_rel ready=%b level=%0d want 1 7", cam_ready, fifo_level);
    end
    cpu_req = 1'b0;
    for (int d = 0; d < 8; d++) step();
    @(negedge clk);
    checks++;
    if (fifo_level !== 4'd0) begin
      failures++;
      $display("FAIL full_drain level=%0d want 0", fifo_level);
    end
    step();
  endtask

  task automatic test_reset_mid();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
    cam_valid = 1'b1; cam_addr = 32'h400; cam_data = 32'h4;
    step();
    cam_addr = 32'h401;
    step();
    cam_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_stall !== 1'b0 || ram_we !== 1'b0 || fifo_level !== 4'd2) begin
      failures++;
      $display("FAIL mid_load stall=%b we=%b level=%0d want 0 0 2",
               cpu_stall, ram_we, fifo_level);
    end
    step();
    reset = 1'b0;
    cpu_we = 1'b1;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      checks++;
      if (cpu_rvalid !== 1'b0 || fifo_level !== 4'd0 || ram_we !== 1'b0) begin
        failures++;
        $display("FAIL mid_rst%0d rvalid=%b level=%0d we=%b want 0 0 0",
                 r, cpu_rvalid, fifo_level, ram_we);
      end
      step();
    end
    reset = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b0 || fifo_level !== 4'd0 || cpu_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL mid_rel we=%b level=%0d rvalid=%b want 0 0 0",
               ram_we, fifo_level, cpu_rvalid);
    end
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_load();
    test_cam_burst();
    test_starvation();
    test_full();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
